// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encodings, requester ids and default memory depth for dmem_arbiter.
package dmem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;
    localparam logic REQ_M0    = 1'b0;
    localparam logic REQ_M1    = 1'b1;
    localparam int   DEPTH_DEF = 256;
endpackage

// File: rtl/dmem_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way round-robin pick; prio names the favoured requester on a tie.
module rr_arbiter_2 (
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       prio_i,
    output logic [1:0] grant_o,
    output logic       winner_o
);
    always_comb begin
        winner_o = (valid0_i && valid1_i) ? prio_i : valid1_i;
        grant_o  = {valid1_i & winner_o, valid0_i & ~winner_o};
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between two valid/ready requesters
// with round-robin arbitration, one-cycle memory access and a held registered response.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_write,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [DATA_W-1:0] m0_req_wdata,
    output logic              m0_resp_valid,
    input  logic              m0_resp_ready,
    output logic [DATA_W-1:0] m0_resp_rdata,
    output logic              m0_resp_err,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_write,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_wdata,
    output logic              m1_resp_valid,
    input  logic              m1_resp_ready,
    output logic [DATA_W-1:0] m1_resp_rdata,
    output logic              m1_resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);
    state_t            state_q;
    logic              prio_q, owner_q, write_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [1:0]        grant;
    logic              winner, idle, acc_ok, resp_hs;
    logic [ADDR_W-1:0] sel_addr;

    assign idle = (state_q == IDLE);

    rr_arbiter_2 u_arb (
        .valid0_i (m0_req_valid & idle),
        .valid1_i (m1_req_valid & idle),
        .prio_i   (prio_q),
        .grant_o  (grant),
        .winner_o (winner)
    );

    always_comb begin
        m0_req_ready   = grant[0];
        m1_req_ready   = grant[1];
        sel_addr       = winner ? m1_req_addr : m0_req_addr;
        acc_ok         = (state_q == ACCESS) && !err_q;
        mem_read       = acc_ok & ~write_q;
        mem_write      = acc_ok & write_q;
        mem_address    = acc_ok ? addr_q : '0;
        mem_write_data = acc_ok ? wdata_q : '0;
        m0_resp_valid  = (state_q == RESP) && (owner_q == REQ_M0);
        m1_resp_valid  = (state_q == RESP) && (owner_q == REQ_M1);
        m0_resp_rdata  = m0_resp_valid ? rdata_q : '0;
        m1_resp_rdata  = m1_resp_valid ? rdata_q : '0;
        m0_resp_err    = m0_resp_valid & err_q;
        m1_resp_err    = m1_resp_valid & err_q;
        resp_hs        = owner_q ? m1_resp_ready : m0_resp_ready;
    end

    // Out-of-range requests still walk ACCESS and RESP so every accept gets exactly one response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= REQ_M0;
            owner_q <= REQ_M0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (|grant) begin
                    state_q <= ACCESS;
                    owner_q <= winner;
                    addr_q  <= sel_addr;
                    wdata_q <= winner ? m1_req_wdata : m0_req_wdata;
                    write_q <= winner ? m1_req_write : m0_req_write;
                    err_q   <= sel_addr >= ADDR_W'(DEPTH);
                end
                ACCESS: begin
                    rdata_q <= (!write_q && !err_q) ? mem_read_data : '0;
                    state_q <= RESP;
                end
                RESP: if (resp_hs) begin
                    prio_q  <= ~owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural 256x64 memory.
module tb_dmem_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0, pre = 1'b1;
    logic        m0_req_valid = 0, m0_req_write = 0, m0_resp_ready = 0;
    logic        m1_req_valid = 0, m1_req_write = 0, m1_resp_ready = 0;
    logic [63:0] m0_req_addr = 0, m0_req_wdata = 0, m1_req_addr = 0, m1_req_wdata = 0;
    logic        m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid;
    logic        m0_resp_err, m1_resp_err, mem_read, mem_write;
    logic [63:0] m0_resp_rdata, m1_resp_rdata, mem_address, mem_write_data, mem_read_data;
    logic [63:0] mem [0:255];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_write(m0_req_write),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_resp_valid(m0_resp_valid),
        .m0_resp_ready(m0_resp_ready), .m0_resp_rdata(m0_resp_rdata), .m0_resp_err(m0_resp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_write(m1_req_write),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_resp_valid(m1_resp_valid),
        .m1_resp_ready(m1_resp_ready), .m1_resp_rdata(m1_resp_rdata), .m1_resp_err(m1_resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always @(posedge clk) begin
        if (pre) begin
            for (int i = 0; i < 256; i++) mem[i] <= 64'h0;
            for (int i = 0; i < 4; i++) mem[i] <= 64'hA0 + 64'(i);
            mem[7] <= 64'h77;
        end else if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
    end
    assign mem_read_data = mem_read ? mem[mem_address[7:0]] : 64'h0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        tick;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        tick;
        tick;
        pre = 1'b0;
        #1;
        chk("rst_m0_ready", m0_req_ready, 0);
        chk("rst_m1_ready", m1_req_ready, 0);
        chk("rst_resp_valid", {m0_resp_valid, m1_resp_valid}, 0);
        chk("rst_strobes", {mem_read, mem_write}, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_rdata", m0_resp_rdata | m1_resp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // m0 write addr 5
        m0_req_valid = 1; m0_req_write = 1; m0_req_addr = 5; m0_req_wdata = 64'hDEAD_BEEF_0000_0001;
        #1;
        chk("w_m0_ready", m0_req_ready, 1);
        chk("w_m1_ready", m1_req_ready, 0);
        tick;
        m0_req_valid = 0;
        chk("w_acc_write", mem_write, 1);
        chk("w_acc_read", mem_read, 0);
        chk("w_acc_addr", mem_address, 5);
        chk("w_acc_wdata", mem_write_data, 64'hDEAD_BEEF_0000_0001);
        chk("w_acc_nov", m0_resp_valid, 0);
        chk("w_acc_ready", m0_req_ready, 0);
        tick;
        chk("w_resp_valid", m0_resp_valid, 1);
        chk("w_resp_rdata", m0_resp_rdata, 0);
        chk("w_resp_err", m0_resp_err, 0);
        chk("w_resp_strobe", mem_write, 0);
        chk("w_mem5", mem[5], 64'hDEAD_BEEF_0000_0001);
        m0_resp_ready = 1;
        tick;
        m0_resp_ready = 0;

        // m0 read addr 5
        m0_req_valid = 1; m0_req_write = 0;
        #1;
        chk("r_m0_ready", m0_req_ready, 1);
        tick;
        m0_req_valid = 0;
        chk("r_acc_read", mem_read, 1);
        chk("r_acc_write", mem_write, 0);
        chk("r_acc_addr", mem_address, 5);
        tick;
        chk("r_resp_valid", m0_resp_valid, 1);
        chk("r_resp_rdata", m0_resp_rdata, 64'hDEAD_BEEF_0000_0001);
        chk("r_m1_quiet", m1_resp_valid, 0);
        m0_resp_ready = 1;
        tick;
        m0_resp_ready = 0;

        // simultaneous requests after reset: m0 first, then m1 beats a re-raised m0
        do_reset;
        m0_req_valid = 1; m0_req_write = 0; m0_req_addr = 1;
        m1_req_valid = 1; m1_req_write = 0; m1_req_addr = 2;
        #1;
        chk("s_m0_ready", m0_req_ready, 1);
        chk("s_m1_ready", m1_req_ready, 0);
        tick;
        m0_req_valid = 0;
        chk("s_acc_addr1", mem_address, 1);
        chk("s_acc_m1_ready", m1_req_ready, 0);
        tick;
        chk("s_m0_rdata", m0_resp_rdata, 64'hA1);
        chk("s_m1_nov", m1_resp_valid, 0);
        chk("s_resp_m1_ready", m1_req_ready, 0);
        m0_resp_ready = 1;
        tick;
        m0_resp_ready = 0;
        m0_req_valid = 1; m0_req_addr = 3;
        #1;
        chk("s_prio_m1_ready", m1_req_ready, 1);
        chk("s_prio_m0_ready", m0_req_ready, 0);
        tick;
        m1_req_valid = 0;
        chk("s_acc_addr2", mem_address, 2);
        tick;
        chk("s_m1_valid", m1_resp_valid, 1);
        chk("s_m1_rdata", m1_resp_rdata, 64'hA2);
        chk("s_m0_nov", m0_resp_valid, 0);
        chk("s_m0_rdata0", m0_resp_rdata, 0);
        m1_resp_ready = 1;
        tick;
        m1_resp_ready = 0;
        #1;
        chk("s_m0_next_ready", m0_req_ready, 1);
        tick;
        m0_req_valid = 0;
        tick;
        chk("s_m0_rdata3", m0_resp_rdata, 64'hA3);
        m0_resp_ready = 1;
        tick;
        m0_resp_ready = 0;

        // m1 write out of range
        m1_req_valid = 1; m1_req_write = 1; m1_req_addr = 256; m1_req_wdata = 64'hFFFF;
        #1;
        chk("e_m1_ready", m1_req_ready, 1);
        tick;
        m1_req_valid = 0;
        chk("e_acc_strobes", {mem_read, mem_write}, 0);
        tick;
        chk("e_resp_valid", m1_resp_valid, 1);
        chk("e_resp_err", m1_resp_err, 1);
        chk("e_resp_rdata", m1_resp_rdata, 0);
        chk("e_m0_err", m0_resp_err, 0);
        chk("e_mem0", mem[0], 64'hA0);
        m1_resp_ready = 1;
        tick;
        m1_resp_ready = 0;

        // backpressure on m0 while m1 waits
        m0_req_valid = 1; m0_req_write = 0; m0_req_addr = 5;
        m1_req_valid = 1; m1_req_write = 0; m1_req_addr = 1;
        #1;
        chk("b_m0_ready", m0_req_ready, 1);
        tick;
        m0_req_valid = 0;
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("b_hold_valid", m0_resp_valid, 1);
            chk("b_hold_rdata", m0_resp_rdata, 64'hDEAD_BEEF_0000_0001);
            chk("b_m1_blocked", m1_req_ready, 0);
            tick;
        end
        m0_resp_ready = 1;
        tick;
        m0_resp_ready = 0;
        #1;
        chk("b_m1_ready", m1_req_ready, 1);
        tick;
        m1_req_valid = 0;
        chk("b_acc_read", mem_read, 1);
        chk("b_acc_addr", mem_address, 1);
        tick;
        chk("b_m1_rdata", m1_resp_rdata, 64'hA1);
        m1_resp_ready = 1;
        tick;
        m1_resp_ready = 0;

        // reset during ACCESS of an m0 write
        m0_req_valid = 1; m0_req_write = 1; m0_req_addr = 7; m0_req_wdata = 64'h1234;
        tick;
        m0_req_valid = 0;
        chk("x_acc_write", mem_write, 1);
        rst_n = 1'b0;
        #1;
        chk("x_write_drop", mem_write, 0);
        chk("x_addr_zero", mem_address, 0);
        chk("x_outs_zero", {m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, mem_read}, 0);
        tick;
        chk("x_mem7", mem[7], 64'h77);
        chk("x_rst_resp", {m0_resp_valid, m1_resp_valid, m0_resp_err, m1_resp_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m0_req_valid = 1; m0_req_write = 0; m0_req_addr = 0;
        m1_req_valid = 1; m1_req_write = 0; m1_req_addr = 0;
        #1;
        chk("x_idle_prio0_m0", m0_req_ready, 1);
        chk("x_idle_prio0_m1", m1_req_ready, 0);
        m0_req_valid = 0; m1_req_valid = 0;
        #1;
        chk("x_idle_noreq", {m0_req_ready, m1_req_ready}, 0);

        // back-to-back lone m1 reads, addr 0..3
        do_reset;
        m1_resp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            m1_req_valid = 1; m1_req_write = 0; m1_req_addr = 64'(i);
            #1;
            chk("bb_ready", m1_req_ready, 1);
            tick;
            m1_req_valid = 0;
            chk("bb_acc_busy", m1_req_ready, 0);
            tick;
            chk("bb_valid", m1_resp_valid, 1);
            chk("bb_m0_quiet", m0_resp_valid, 0);
            case (i)
                0: chk("bb_rdata0", m1_resp_rdata, 64'hA0);
                1: chk("bb_rdata1", m1_resp_rdata, 64'hA1);
                2: chk("bb_rdata2", m1_resp_rdata, 64'hA2);
                default: chk("bb_rdata3", m1_resp_rdata, 64'hA3);
            endcase
            tick;
        end
        m1_resp_ready = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
